// File: rtl/midi_burst_builder_if.sv
// MIDI byte input and burst output bundle between UART RX, the burst builder and pwm_combine.
interface midi_burst_builder_if;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        midi_burst_change_out;
    logic [4:0]  on_array_out;
    logic [15:0] midi_burst_data_out [5];
    logic        overflow_out;
    logic [1:0]  state_out;

    modport master (
        output byte_in, byte_valid_in,
        input  midi_burst_change_out, on_array_out, midi_burst_data_out, overflow_out, state_out
    );

    modport slave (
        input  byte_in, byte_valid_in,
        output midi_burst_change_out, on_array_out, midi_burst_data_out, overflow_out, state_out
    );
endinterface

// File: rtl/midi_burst_builder.sv
// Parses the MIDI byte stream into a 5-voice note table and publishes it as a MIDI burst.
// state       | meaning
// WAIT_STATUS | no usable running status, data bytes dropped
// WAIT_D1     | running status held, waiting for first data byte (note / controller)
// WAIT_D2     | first data byte latched, waiting for velocity / value
// APPLY       | one cycle: message applied to the note table
module midi_burst_builder #(
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input logic            clk_in,
    input logic            rst_in,
    midi_burst_builder_if.slave bus
);
    typedef enum logic [1:0] {WAIT_STATUS = 2'd0, WAIT_D1 = 2'd1, WAIT_D2 = 2'd2, APPLY = 2'd3} state_t;
    typedef enum logic [1:0] {MSG_NONE, MSG_OFF, MSG_ON, MSG_CC} msg_t;

    localparam logic [3:0] CH = 4'(CHANNEL);

    state_t      state;
    msg_t        run_msg;
    logic [6:0]  d1, d2;
    logic [4:0]  on_r;
    logic [15:0] data_r [5];
    logic        change_r, ovf_r;

    logic       is_rt, is_status, ch_ok;
    msg_t       byte_msg;
    logic       hit, free_found, do_release;
    logic [2:0] hit_idx, free_idx;

    always_comb begin
        is_rt     = (bus.byte_in >= 8'hF8);
        is_status = bus.byte_in[7] && !is_rt;
        ch_ok     = OMNI || (bus.byte_in[3:0] == CH);
        byte_msg  = MSG_NONE;
        if (ch_ok) begin
            case (bus.byte_in[7:4])
                4'h8:    byte_msg = MSG_OFF;
                4'h9:    byte_msg = MSG_ON;
                4'hB:    byte_msg = MSG_CC;
                default: byte_msg = MSG_NONE;
            endcase
        end
    end

    // Scanning downward leaves the lowest-indexed free voice selected.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = 3'd0;
        free_found = 1'b0;
        free_idx   = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (on_r[i] && (data_r[i][14:8] == d1)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
            if (!on_r[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
        do_release = (run_msg == MSG_OFF) || ((run_msg == MSG_ON) && (d2 == 7'd0));
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= WAIT_STATUS;
            run_msg  <= MSG_NONE;
            d1       <= '0;
            d2       <= '0;
            on_r     <= '0;
            change_r <= 1'b0;
            ovf_r    <= 1'b0;
            for (int i = 0; i < 5; i++) data_r[i] <= '0;
        end else begin
            change_r <= 1'b0;
            ovf_r    <= 1'b0;

            if (state == APPLY) begin
                state <= WAIT_D1;
                if (do_release) begin
                    if (hit) begin
                        on_r[hit_idx]   <= 1'b0;
                        data_r[hit_idx] <= '0;
                        change_r        <= 1'b1;
                    end
                end else if (run_msg == MSG_ON) begin
                    if (hit) begin
                        data_r[hit_idx] <= {1'b0, d1, 1'b0, d2};
                        change_r        <= 1'b1;
                    end else if (free_found) begin
                        on_r[free_idx]   <= 1'b1;
                        data_r[free_idx] <= {1'b0, d1, 1'b0, d2};
                        change_r         <= 1'b1;
                    end else begin
                        ovf_r <= 1'b1;
                    end
                end else if (run_msg == MSG_CC) begin
                    if (((d1 == 7'd123) || (d1 == 7'd120)) && (|on_r)) begin
                        on_r     <= '0;
                        change_r <= 1'b1;
                        for (int i = 0; i < 5; i++) data_r[i] <= '0;
                    end
                end
            end

            // A byte landing in APPLY overrides the return to WAIT_D1 and is parsed from there.
            if (bus.byte_valid_in && !is_rt) begin
                if (is_status) begin
                    run_msg <= byte_msg;
                    state   <= (byte_msg != MSG_NONE) ? WAIT_D1 : WAIT_STATUS;
                end else begin
                    case (state)
                        WAIT_D1, APPLY: begin
                            d1    <= bus.byte_in[6:0];
                            state <= WAIT_D2;
                        end
                        WAIT_D2: begin
                            d2    <= bus.byte_in[6:0];
                            state <= APPLY;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.midi_burst_change_out = change_r;
    assign bus.overflow_out          = ovf_r;
    assign bus.on_array_out          = on_r;
    assign bus.midi_burst_data_out   = data_r;
    assign bus.state_out             = state;
endmodule

// File: tb/tb_midi_burst_builder.sv
// Scoreboard bench for midi_burst_builder: expected table snapshots are queued per message
// and compared by a monitor whenever the DUT strobes.
module tb_midi_burst_builder;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    midi_burst_builder_if bus ();

    midi_burst_builder #(.CHANNEL(0), .OMNI(1'b0)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    typedef struct packed {
        logic        is_ovf;
        logic [4:0]  on;
        logic [79:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          asserts = 0;
    int          fails   = 0;
    int          cyc     = 0;
    int          last_cyc = 0;
    logic [4:0]  exp_on;
    logic [15:0] exp_data [5];

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [79:0] pack_exp();
        return {exp_data[4], exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
    endfunction

    function automatic logic [79:0] dut_data();
        return {bus.midi_burst_data_out[4], bus.midi_burst_data_out[3], bus.midi_burst_data_out[2],
                bus.midi_burst_data_out[1], bus.midi_burst_data_out[0]};
    endfunction

    task automatic clear_exp();
        exp_on = '0;
        for (int i = 0; i < 5; i++) exp_data[i] = '0;
    endtask

    task automatic push_exp(input logic is_ovf);
        exp_t e;
        e.is_ovf = is_ovf;
        e.on     = exp_on;
        e.data   = pack_exp();
        e.cyc    = last_cyc + 2;
        q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in);
        bus.byte_in       = b;
        bus.byte_valid_in = 1'b1;
        last_cyc          = cyc;
        @(negedge clk_in);
        bus.byte_valid_in = 1'b0;
    endtask

    task automatic send3(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
        send_byte(s);
        send_byte(a);
        send_byte(b);
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b);
        send_byte(a);
        send_byte(b);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        asserts++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d expected strobes still pending, required 0", name, q.size());
            q.delete();
        end
        repeat (4) @(negedge clk_in);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in && (bus.midi_burst_change_out || bus.overflow_out)) begin
            asserts++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: change=%b overflow=%b on=%b at cycle %0d, required no strobe",
                         bus.midi_burst_change_out, bus.overflow_out, bus.on_array_out, cyc);
            end else begin
                e = q.pop_front();
                if ({bus.midi_burst_change_out, bus.overflow_out} !== {~e.is_ovf, e.is_ovf}) begin
                    fails++;
                    $display("FAIL strobe_kind: change/overflow=%b%b, required %b%b",
                             bus.midi_burst_change_out, bus.overflow_out, ~e.is_ovf, e.is_ovf);
                end
                asserts++;
                if (bus.on_array_out !== e.on) begin
                    fails++;
                    $display("FAIL on_array: got %b, required %b", bus.on_array_out, e.on);
                end
                asserts++;
                if (dut_data() !== e.data) begin
                    fails++;
                    $display("FAIL burst_data: got %h, required %h", dut_data(), e.data);
                end
                asserts++;
                if (cyc !== e.cyc) begin
                    fails++;
                    $display("FAIL strobe_latency: strobe at cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic test_reset();
        bus.byte_in       = 8'h00;
        bus.byte_valid_in = 1'b0;
        rst_in            = 1'b0;
        clear_exp();
        repeat (3) @(negedge clk_in);
        asserts++;
        if ({bus.midi_burst_change_out, bus.overflow_out, bus.on_array_out, bus.state_out} !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs: chg=%b ovf=%b on=%b state=%0d, required all 0",
                     bus.midi_burst_change_out, bus.overflow_out, bus.on_array_out, bus.state_out);
        end
        asserts++;
        if (dut_data() !== 80'd0) begin
            fails++;
            $display("FAIL reset_data: got %h, required 0", dut_data());
        end
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        asserts++;
        if (bus.state_out !== 2'd0) begin
            fails++;
            $display("FAIL reset_state_after_release: got %0d, required 0", bus.state_out);
        end
    endtask

    task automatic test_basic_note_on();
        send_byte(8'h90);
        asserts++;
        if (bus.state_out !== 2'd1) begin
            fails++;
            $display("FAIL state_wait_d1: got %0d, required 1", bus.state_out);
        end
        send2(8'h3C, 8'h64);
        exp_on = 5'b00001; exp_data[0] = 16'h3C64; push_exp(1'b0);
        drain("basic");
    endtask

    task automatic test_running_status();
        send2(8'h40, 8'h50);
        exp_on = 5'b00011; exp_data[1] = 16'h4050; push_exp(1'b0);
        send2(8'h3C, 8'h00);
        exp_on = 5'b00010; exp_data[0] = 16'h0000; push_exp(1'b0);
        drain("running_status");
    endtask

    task automatic test_overflow();
        send3(8'h80, 8'h40, 8'h00);
        exp_on = 5'b00000; exp_data[1] = 16'h0000; push_exp(1'b0);
        send_byte(8'h90);
        for (int i = 0; i < 5; i++) begin
            send2(8'(8'h3C + i), 8'h40);
            exp_on[i] = 1'b1;
            exp_data[i] = {8'(8'h3C + i), 8'h40};
            push_exp(1'b0);
        end
        send2(8'h41, 8'h40);
        push_exp(1'b1);
        drain("overflow");
    endtask

    task automatic test_retrigger();
        send2(8'h3C, 8'h20);
        exp_data[0] = 16'h3C20; push_exp(1'b0);
        send2(8'h3C, 8'h70);
        exp_data[0] = 16'h3C70; push_exp(1'b0);
        send3(8'h80, 8'h45, 8'h00);
        drain("retrigger");
    endtask

    task automatic test_all_notes_off_full();
        send3(8'hB0, 8'h7B, 8'h00);
        clear_exp(); push_exp(1'b0);
        send3(8'hB0, 8'h7B, 8'h00);
        drain("all_notes_off_full");
    endtask

    task automatic test_filtering();
        send3(8'h91, 8'h3C, 8'h64);
        asserts++;
        if (bus.state_out !== 2'd0) begin
            fails++;
            $display("FAIL state_filtered: got %0d, required 0", bus.state_out);
        end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        exp_on = 5'b00001; exp_data[0] = 16'h3C64; push_exp(1'b0);
        send_byte(8'h90); send_byte(8'h3D); send_byte(8'hF0); send_byte(8'h64);
        drain("filtering");
    endtask

    task automatic test_all_notes_off();
        send3(8'h90, 8'h3E, 8'h11);
        exp_on = 5'b00011; exp_data[1] = 16'h3E11; push_exp(1'b0);
        send2(8'h3F, 8'h22);
        exp_on = 5'b00111; exp_data[2] = 16'h3F22; push_exp(1'b0);
        send3(8'hB0, 8'h07, 8'h10);
        send3(8'hB0, 8'h78, 8'h00);
        clear_exp(); push_exp(1'b0);
        drain("all_notes_off");
    endtask

    task automatic test_reset_mid_message();
        send3(8'h90, 8'h30, 8'h10);
        exp_on = 5'b00001; exp_data[0] = 16'h3010; push_exp(1'b0);
        drain("pre_reset");
        send_byte(8'h90);
        rst_in = 1'b0;
        clear_exp();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        send2(8'h3C, 8'h64);
        drain("reset_mid_message");
        asserts++;
        if ({bus.on_array_out, bus.state_out} !== 7'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: on=%b state=%0d, required 0", bus.on_array_out, bus.state_out);
        end
        asserts++;
        if (dut_data() !== 80'd0) begin
            fails++;
            $display("FAIL reset_mid_data: got %h, required 0", dut_data());
        end
    endtask

    initial begin
        test_reset();
        test_basic_note_on();
        test_running_status();
        test_overflow();
        test_retrigger();
        test_all_notes_off_full();
        test_filtering();
        test_all_notes_off();
        test_reset_mid_message();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/midi_burst_builder.md
# midi_burst_builder

Parses the MIDI byte stream from the UART receiver into a 5-voice note table and publishes it as a "MIDI burst", the interface `pwm_combine` consumes. The burst is a one-cycle change strobe plus a per-voice on-mask and per-voice {note, velocity} words. It sits between the MIDI UART RX and `pwm_combine`. It implements Note On, Note Off, running status, channel filtering, realtime-byte transparency and All Notes Off.

## Interface
- `CHANNEL`, default 0: MIDI channel (0-15) accepted when `OMNI`=0.
- `OMNI`, default 0: 1 = accept Note On/Off/CC on all channels.
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset, asynchronous, active-low.
- `byte_in` input 8: received MIDI byte, valid while `byte_valid_in`=1.
- `byte_valid_in` input 1: one-cycle strobe per byte. Upstream guarantees it is never high on two consecutive cycles.
- `midi_burst_change_out` output 1: one-cycle strobe, the note table changed.
- `on_array_out` output 5: bit i = voice i holds a sounding note.
- `midi_burst_data_out[4:0]` output 16 each: [15:8] = {0, note[6:0]}, [7:0] = {0, velocity[6:0]}. Bit 15 and bit 7 are always 0.
- `overflow_out` output 1: one-cycle strobe, a Note On was dropped because all 5 voices were busy.
- `state_out` output 2: parser state encoding, for debug.

## Operation
Parser states are WAIT_STATUS, WAIT_D1, WAIT_D2 and APPLY.

**Byte classification**
- Realtime bytes (0xF8-0xFF) are ignored entirely. They do not change state or running status.
- Any other byte with bit 7 set is a status byte:
  - 0x8n, 0x9n or 0xBn whose channel matches (n == `CHANNEL`, or `OMNI`=1): latch it as the running status and go to WAIT_D1.
  - Any other status byte (wrong channel, other message type, or system common 0xF0-0xF7): clear running status and go to WAIT_STATUS.
- Data bytes (bit 7 = 0):
  - In WAIT_STATUS: data bytes are dropped.
  - In WAIT_D1: latch the byte as d1 and go to WAIT_D2.
  - In WAIT_D2: latch the byte as d2 and go to APPLY.

**APPLY (exactly one cycle)**
- Returns to WAIT_D1, keeping the running status, so the next data byte starts a new message.
- Note On with d2 ≠ 0:
  - If a busy voice already holds note d1, overwrite its velocity with d2 and raise the change strobe.
  - Otherwise, if a free voice exists, take the lowest-indexed free voice: set its on bit, write {d1, d2}, and raise the change strobe.
  - Otherwise pulse `overflow_out`; the table and the strobe are unchanged.
- Note On with d2 = 0, or any Note Off:
  - If a busy voice holds note d1, clear its on bit, set its data to 16'h0000, and raise the change strobe.
  - Otherwise do nothing and raise no strobe.
  - At most one voice ever holds a given note.
- CC with d1 = 123 (All Notes Off) or d1 = 120 (All Sound Off):
  - If any voice is busy, clear all voices and all data and raise the change strobe.
  - If no voice is busy, do nothing.
- Any other CC is ignored.

**Output stability**
- `on_array_out` and `midi_burst_data_out` are registers. They are stable in the strobe cycle and held until the next change.
- `pwm_combine` samples them on the strobe cycle.

## Timing
- Reset (`rst_in`=0, asynchronous) sets:
  - all outputs to 0; data words to 16'h0000;
  - running status cleared;
  - state WAIT_STATUS, `state_out`=0.
- Reset asserted mid-message discards the partial message. No strobe follows the release of reset.
- Latency:
  - The d2 byte is accepted on edge E, and the state is APPLY during cycle E→E+1.
  - The table registers update on edge E+1, together with `midi_burst_change_out`=1 or `overflow_out`=1.
  - The strobe falls on edge E+2.
- A byte arriving during the APPLY cycle is parsed normally from WAIT_D1. No byte is lost, given the no-consecutive-strobes guarantee.
- A status byte in WAIT_D2 aborts the pending message. A realtime byte between d1 and d2 does not abort it.
- At most one strobe is produced per completed message.

## Test plan
- **Basic note on.** Reset, then bytes 0x90, 0x3C, 0x64 → two cycles after the last byte, one-cycle change strobe; `on_array_out`=5'b00001; data[0]=16'h3C64.
- **Running status and Note On velocity 0.** Continue with 0x40, 0x50, then 0x3C, 0x00 → first strobe: on=5'b00011, data[1]=16'h4050. Second strobe: on=5'b00010, data[0]=16'h0000.
- **Overflow.** Send six Note Ons for notes 60-65 → five strobes filling voices 0-4, on=5'b11111. The sixth message produces `overflow_out` for one cycle, no strobe, and the table is unchanged.
- **Retrigger and unmatched off.** Send Note On 60 velocity 0x20, then Note On 60 velocity 0x70 → the same voice is updated to 16'h3C70, with a strobe each time. Then Note Off 0x80, 0x45, 0x00 for an unheld note → no strobe.
- **Filtering and realtime bytes.** With `CHANNEL`=0, send 0x91, 0x3C, 0x64 → no strobe. Send 0x90, 0x3C, 0xF8, 0x64 → normal strobe. Send 0x90, 0x3C, 0xF0, 0x64 → no strobe.
- **All Notes Off and reset.** With three voices on, send 0xB0, 0x7B, 0x00 → one strobe; on=0; all data 0. Assert `rst_in` low for 3 cycles between 0x90 and 0x3C, then release → all outputs 0 and no strobe.
